// File: rtl/neo_wb_mem_res_bridge.sv
// Wishbone slave that pairs 32-bit LO/HI writes into 64-bit words and drains them through a small FIFO.
// Optional overflow interrupt on irq_o when NEO_WB_BRIDGE_IRQ_EN is defined.
module neo_wb_mem_res_bridge #(
   parameter int FIFO_AW = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic [63:0] mem_res_wr_dta,
   output logic        mem_res_wr_en,
   input  logic        mem_res_wr_almost_full,
   output logic        irq_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

   logic [31:0]        holding_lo, holding_hi;
   logic [31:0]        lo_new, hi_new;
   logic [63:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               overflow;
   logic [15:0]        drop_cnt;
   logic [31:0]        rd_mux;
   logic [1:0]         reg_sel;
   logic               req, wr_fire;
   logic               lo_wr, hi_wr, stat_wr, drop_wr;
   logic               full, empty, push, pop, drop;
   logic [3:0]         count4;
   logic               unused_adr;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return r;
   endfunction

   assign reg_sel    = wb_adr_i[3:2];
   assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

   // Wishbone: a request is acked one cycle later; writes take effect in the ack cycle,
   // and the master holds its signals until it has seen the ack.
   assign req     = wb_stb_i & wb_cyc_i;
   assign wr_fire = wb_ack_o & req & wb_we_i;
   assign lo_wr   = wr_fire & (reg_sel == 2'd0);
   assign hi_wr   = wr_fire & (reg_sel == 2'd1);
   assign stat_wr = wr_fire & (reg_sel == 2'd2);
   assign drop_wr = wr_fire & (reg_sel == 2'd3);

   assign lo_new = merge_bytes(holding_lo, wb_dat_i, wb_sel_i);
   assign hi_new = merge_bytes(holding_hi, wb_dat_i, wb_sel_i);

   assign full   = (count == DEPTH_C);
   assign empty  = (count == '0);
   assign count4 = 4'(count);
   assign pop    = ~empty & ~mem_res_wr_almost_full;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push   = hi_wr & (~full | pop);
   assign drop   = hi_wr & ~push;

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         2'd0: rd_mux = holding_lo;
         2'd1: rd_mux = holding_hi;
         2'd2: rd_mux = {24'b0, count4, 1'b0, full, empty, overflow};
         2'd3: rd_mux = {16'b0, drop_cnt};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {hi_new, holding_lo};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_ack_o       <= 1'b0;
         wb_dat_o       <= '0;
         holding_lo     <= '0;
         holding_hi     <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         overflow       <= 1'b0;
         drop_cnt       <= '0;
         mem_res_wr_en  <= 1'b0;
         mem_res_wr_dta <= '0;
      end else begin
         wb_ack_o <= req & ~wb_ack_o;
         wb_dat_o <= (req & ~wb_ack_o & ~wb_we_i) ? rd_mux : '0;
         if (lo_wr) holding_lo <= lo_new;
         if (hi_wr) holding_hi <= hi_new;
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         mem_res_wr_en <= pop;
         if (pop) mem_res_wr_dta <= mem[rd_ptr];
         // Setting beats a simultaneous W1C clear.
         if (drop)
            overflow <= 1'b1;
         else if (stat_wr && wb_dat_i[0])
            overflow <= 1'b0;
         if (drop_wr)
            drop_cnt <= '0;
         else if (drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

`ifdef NEO_WB_BRIDGE_IRQ_EN
   assign irq_o = overflow;
`else
   assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_neo_wb_mem_res_bridge.sv
// Directed self-checking bench for neo_wb_mem_res_bridge (LO/HI pairing, FIFO drain, overflow, reset).
module tb_neo_wb_mem_res_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
   logic [3:0]  wb_sel_i;
   logic [63:0] mem_res_wr_dta;
   logic        mem_res_wr_en, mem_res_wr_almost_full, irq_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc_cnt = 0;
   int          ack_cyc = 0;
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];
   int          stamp_q[$];
   logic [31:0] rd;
   logic        exp_irq;

   neo_wb_mem_res_bridge #(.FIFO_AW(2)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .wb_adr_i               (wb_adr_i),
      .wb_dat_i               (wb_dat_i),
      .wb_dat_o               (wb_dat_o),
      .wb_we_i                (wb_we_i),
      .wb_sel_i               (wb_sel_i),
      .wb_stb_i               (wb_stb_i),
      .wb_cyc_i               (wb_cyc_i),
      .wb_ack_o               (wb_ack_o),
      .mem_res_wr_dta         (mem_res_wr_dta),
      .mem_res_wr_en          (mem_res_wr_en),
      .mem_res_wr_almost_full (mem_res_wr_almost_full),
      .irq_o                  (irq_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (!rst && mem_res_wr_en) begin
         got_q.push_back(mem_res_wr_dta);
         stamp_q.push_back(cyc_cnt);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wb_xfer(input logic [1:0] idx, input logic we, input logic [31:0] d,
                          input logic [3:0] sel, output logic [31:0] rdata);
      logic seen;
      seen     = 1'b0;
      rdata    = '0;
      wb_adr_i = {28'b0, idx, 2'b00};
      wb_we_i  = we;
      wb_dat_i = d;
      wb_sel_i = sel;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(posedge clk); #1;
         if (wb_ack_o) begin
            seen    = 1'b1;
            rdata   = wb_dat_o;
            ack_cyc = cyc_cnt;
         end
      end
      check("ack_seen", 64'(seen), 64'd1);
      @(posedge clk); #1;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic wb_wr(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_xfer(idx, 1'b1, d, sel, dummy);
   endtask

   task automatic wb_rd(input logic [1:0] idx, output logic [31:0] rdata);
      wb_xfer(idx, 1'b0, 32'h0, 4'hF, rdata);
   endtask

   initial begin
      rst = 1'b1;
      wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_sel_i = '0;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; mem_res_wr_almost_full = 1'b0;
`ifdef NEO_WB_BRIDGE_IRQ_EN
      exp_irq = 1'b1;
`else
      exp_irq = 1'b0;
`endif
      #1;
      check("rst_ack", 64'(wb_ack_o), 64'd0);
      check("rst_dat", 64'(wb_dat_o), 64'd0);
      check("rst_wr_en", 64'(mem_res_wr_en), 64'd0);
      check("rst_dta", mem_res_wr_dta, 64'd0);
      check("rst_irq", 64'(irq_o), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // single word, latency 2 clocks after the HI ack
      wb_wr(2'd0, 32'h01234567, 4'hF);
      wb_wr(2'd1, 32'hDEADBEEF, 4'hF);
      repeat (4) @(posedge clk);
      #1;
      check("t1_count", 64'(got_q.size()), 64'd1);
      if (got_q.size() == 1) begin
         check("t1_data", got_q[0], 64'hDEADBEEF01234567);
         check("t1_latency", 64'(stamp_q[0] - ack_cyc), 64'd2);
      end
      wb_rd(2'd2, rd);
      check("t1_stat", 64'(rd), 64'h00000002);
      got_q.delete(); stamp_q.delete();

      // byte enables
      wb_wr(2'd0, 32'h00000000, 4'hF);
      wb_wr(2'd0, 32'hFFFFAAAA, 4'b0011);
      wb_rd(2'd0, rd);
      check("t4_lo_sel", 64'(rd), 64'h0000AAAA);
      wb_rd(2'd1, rd);
      check("t4_hi_read", 64'(rd), 64'hDEADBEEF);

      // fill under back-pressure
      mem_res_wr_almost_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wb_wr(2'd0, 32'h10000000 + i, 4'hF);
         wb_wr(2'd1, 32'hA0000000 + i, 4'hF);
         exp_q.push_back({32'hA0000000 + i, 32'h10000000 + i});
      end
      wb_rd(2'd2, rd);
      check("t2_stat_full", 64'(rd), 64'h00000044);
      check("t2_no_wr_en", 64'(got_q.size()), 64'd0);

      // overflow
      wb_wr(2'd0, 32'h55555555, 4'hF);
      wb_wr(2'd1, 32'h66666666, 4'hF);
      wb_rd(2'd2, rd);
      check("t3_stat_ovf", 64'(rd), 64'h00000045);
      wb_rd(2'd3, rd);
      check("t3_drop", 64'(rd), 64'd1);
      check("t3_irq_set", 64'(irq_o), 64'(exp_irq));
      wb_wr(2'd2, 32'h00000001, 4'hF);
      wb_rd(2'd2, rd);
      check("t3_stat_clr", 64'(rd), 64'h00000044);
      check("t3_irq_clr", 64'(irq_o), 64'd0);
      wb_wr(2'd3, 32'h00000000, 4'hF);
      wb_rd(2'd3, rd);
      check("t3_drop_clr", 64'(rd), 64'd0);

      // release and drain
      mem_res_wr_almost_full = 1'b0;
      for (int i = 0; i < 50 && got_q.size() < 4; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      check("t2_drain_count", 64'(got_q.size()), 64'd4);
      if (got_q.size() == 4) begin
         for (int i = 0; i < 4; i++) check("t2_drain_data", got_q[i], exp_q[i]);
         check("t2_back_to_back", 64'(stamp_q[3] - stamp_q[0]), 64'd3);
      end
      wb_rd(2'd2, rd);
      check("t2_stat_empty", 64'(rd), 64'h00000002);
      got_q.delete(); stamp_q.delete(); exp_q.delete();

      // held strobe on a STAT read
      wb_adr_i = 32'h8; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
      check("t5_ack0", 64'(wb_ack_o), 64'd0);
      @(posedge clk); #1;
      check("t5_ack1", 64'(wb_ack_o), 64'd1);
      check("t5_dat1", 64'(wb_dat_o), 64'h00000002);
      @(posedge clk); #1;
      check("t5_ack2", 64'(wb_ack_o), 64'd0);
      @(posedge clk); #1;
      check("t5_ack3", 64'(wb_ack_o), 64'd1);
      check("t5_dat3", 64'(wb_dat_o), 64'h00000002);
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      @(posedge clk); #1;

      // reset mid-transfer
      mem_res_wr_almost_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wb_wr(2'd0, 32'hC0000000 + i, 4'hF);
         wb_wr(2'd1, 32'hB0000000 + i, 4'hF);
      end
      wb_adr_i = 32'h8; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
      @(posedge clk); #1;
      check("t6_ack_pending", 64'(wb_ack_o), 64'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_ack", 64'(wb_ack_o), 64'd0);
      check("t6_rst_dat", 64'(wb_dat_o), 64'd0);
      check("t6_rst_wr_en", 64'(mem_res_wr_en), 64'd0);
      check("t6_rst_dta", mem_res_wr_dta, 64'd0);
      check("t6_rst_irq", 64'(irq_o), 64'd0);
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      mem_res_wr_almost_full = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("t6_no_stray_wr_en", 64'(got_q.size()), 64'd0);
      wb_rd(2'd2, rd);
      check("t6_stat", 64'(rd), 64'h00000002);
      wb_rd(2'd0, rd);
      check("t6_lo_cleared", 64'(rd), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
